// File: rtl/mod_n_up_counter.sv
// mod_n_up_counter: modulo-MOD up counter with parallel load, wrap flag/count and load-range error
module mod_n_up_counter #(
  parameter int MOD   = 5,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] Cout,
  output logic             tc,
  output logic             wrap,
  output logic [7:0]       wrap_cnt,
  output logic             load_err
);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [7:0]       wrap_cnt_q, wrap_cnt_d;
  logic             load_err_q, load_err_d;
  logic             at_last, in_range, din_ok, wrap_evt;
  always_comb begin
    at_last    = count_q == LAST;
    in_range   = {1'b0, count_q} < MOD_W;
    din_ok     = {1'b0, din} < MOD_W;
    wrap_evt   = en && !load && at_last;
    count_d    = load ? (din_ok ? din : '0)
               : en ? ((at_last || !in_range) ? '0 : count_q + ONE)
               : count_q;
    wrap_d     = wrap_evt;
    wrap_cnt_d = wrap_cnt_q + {7'd0, wrap_evt};
    load_err_d = load && !din_ok;
  end
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= 8'd0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      load_err_q <= load_err_d;
    end
  end
  assign Cout     = count_q;
  assign tc       = at_last && en && !load;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign load_err = load_err_q;
endmodule
